// File: rtl/conv_frame_mem_pkg.sv
// Shared types and default geometry for the 50x50 convolution frame buffer.
package conv_frame_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DUMP = 2'd3
    } state_t;

    localparam int DEPTH_DEF = 2500;
    localparam int AW_DEF    = 14;
    localparam int DW_DEF    = 8;
    localparam int QUIET_DEF = 16;

    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/conv_frame_ram.sv
// Single-clock frame RAM: one write port, one registered read port.
// Macro CONV_FRAME_MEM_FWD_EN forwards a same-cycle write to the read output.
module conv_frame_ram
    import conv_frame_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic          wr_ok;
    logic          rd_ok;

    // Range checks use the full address so out-of-frame addresses never alias.
    assign wr_ok = wr_en && addr_ok(32'(wr_addr), DEPTH);
    assign rd_ok = addr_ok(32'(rd_addr), DEPTH);

    // Storage array: contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // Registered read, zero for out-of-frame addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!rd_ok) begin
            rd_data <= '0;
`ifdef CONV_FRAME_MEM_FWD_EN
        end else if (wr_ok && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
`endif
        end else begin
            rd_data <= mem[rd_addr[IW-1:0]];
        end
    end

endmodule

// File: rtl/conv_frame_mem.sv
// Frame buffer sequencing load -> engine run -> dump of one 50x50 frame.
// Optional macro CONV_FRAME_MEM_FWD_EN enables write-to-read forwarding in the RAM.
module conv_frame_mem
    import conv_frame_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int QUIET = QUIET_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          start,
    input  logic [AW-1:0] read_select,
    output logic [DW-1:0] read_data,
    input  logic [AW-1:0] ws,
    input  logic          we,
    input  logic [DW-1:0] result,
    input  logic          finish,
    output logic [DW-1:0] dp_data,
    output logic          dp_valid,
    input  logic          dp_ready,
    output logic          dp_last,
    output logic          done
);

    localparam int            QW        = $clog2(QUIET + 1);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET);

    state_t        state;
    logic [AW-1:0] ld_ptr;
    logic [AW-1:0] dp_ptr;
    logic [QW-1:0] quiet;
    logic [QW-1:0] quiet_next;
    logic [AW-1:0] dump_addr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          ld_fire;

    assign ld_fire = (state == LOAD) && ld_valid && ld_ready;

    // Shared write port: loader in LOAD, engine in RUN; never while reset is high.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ld_ptr;
        wr_data = ld_data;
        if (rst) begin
            wr_en = 1'b0;
        end else if (ld_fire) begin
            wr_en = 1'b1;
        end else if ((state == RUN) && we && addr_ok(32'(ws), DEPTH)) begin
            wr_en   = 1'b1;
            wr_addr = ws;
            wr_data = result;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Look one beat ahead on acceptance so the registered RAM output never bubbles.
    always_comb begin
        dump_addr = dp_ptr;
        if ((state == DUMP) && dp_valid && dp_ready && !dp_last) begin
            dump_addr = dp_ptr + 1'b1;
        end else begin
            dump_addr = dp_ptr;
        end
    end

    // Quiet counter next value: any write restarts the idle window.
    always_comb begin
        quiet_next = quiet;
        if (we) begin
            quiet_next = '0;
        end else if (finish && (quiet != QUIET_MAX)) begin
            quiet_next = quiet + 1'b1;
        end else begin
            quiet_next = quiet;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
            start    <= 1'b0;
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            done     <= 1'b0;
            ld_ptr   <= '0;
            dp_ptr   <= '0;
            quiet    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                        ld_ptr   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        if (ld_ptr == LAST) begin
                            state    <= RUN;
                            ld_ready <= 1'b0;
                            start    <= 1'b1;
                            quiet    <= '0;
                        end else begin
                            ld_ptr <= ld_ptr + 1'b1;
                        end
                    end
                end
                RUN: begin
                    quiet <= quiet_next;
                    if (quiet_next == QUIET_MAX) begin
                        state    <= DUMP;
                        start    <= 1'b0;
                        dp_ptr   <= '0;
                        dp_valid <= 1'b0;
                        dp_last  <= 1'b0;
                    end
                end
                DUMP: begin
                    if (!dp_valid) begin
                        dp_valid <= 1'b1;
                        dp_last  <= (dp_ptr == LAST);
                    end else if (dp_ready) begin
                        if (dp_last) begin
                            state    <= IDLE;
                            dp_valid <= 1'b0;
                            dp_last  <= 1'b0;
                            done     <= 1'b1;
                            dp_ptr   <= '0;
                            quiet    <= '0;
                        end else begin
                            dp_ptr  <= dp_ptr + 1'b1;
                            dp_last <= ((dp_ptr + 1'b1) == LAST);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Engine-facing read port.
    conv_frame_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_read_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (read_select),
        .rd_data (read_data)
    );

    // Mirror copy dedicated to the dump stream so read_select stays live in DUMP.
    conv_frame_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dump_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (dump_addr),
        .rd_data (dp_data)
    );

endmodule

// File: doc/conv_frame_mem.md
CONV_FRAME_MEM -- requirements
Module: conv_frame_mem

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 2500, pixel count of one 50x50 frame.
- AW, 14, address width.
- DW, 8, pixel width.
- QUIET, 16, idle-write cycles after finish before dump.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  one-cycle pulse; begins frame load from IDLE.
- ld_data  in  DW  load pixel.
- ld_valid  in  1  load pixel valid.
- ld_ready  out  1  load pixel accepted when ld_valid&&ld_ready.
- start  out  1  engine enable; high throughout RUN.
- read_select  in  AW  engine read address.
- read_data  out  DW  registered read data.
- ws  in  AW  engine write address.
- we  in  1  engine write enable.
- result  in  DW  engine write data.
- finish  in  1  engine done level.
- dp_data  out  DW  dump pixel.
- dp_valid  out  1  dump pixel valid.
- dp_ready  in  1  dump pixel accepted when dp_valid&&dp_ready.
- dp_last  out  1  high with final dump beat.
- done  out  1  one-cycle pulse on DUMP completion.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, RUN, DUMP; reset state IDLE.
REQ-004 IDLE->LOAD on go; go outside IDLE SHALL be ignored.
REQ-005 In LOAD, ld_ready SHALL be 1; each accepted beat writes mem[ld_ptr], ld_ptr increments from 0.
REQ-006 LOAD->RUN in the cycle after beat DEPTH-1 is accepted; ld_ready drops the same edge.
REQ-007 In RUN, start SHALL be 1; in all other states 0.
REQ-008 Read port, all states: read_data SHALL equal mem[read_select] sampled at the previous posedge (1-cycle latency).
REQ-009 read_select >= DEPTH SHALL return 0.
REQ-010 Engine writes SHALL occur only in RUN: we=1 with ws < DEPTH writes result to mem[ws]; ws >= DEPTH is dropped.
REQ-011 Quiet counter, RUN only: clears on any we; increments while finish=1 and we=0; saturates at QUIET.
REQ-012 RUN->DUMP when the quiet counter reaches QUIET; finish=0 holds RUN indefinitely.
REQ-013 DUMP SHALL stream mem[0..DEPTH-1] in order.
- dp_valid rises the second cycle after entry (RAM latency).
- dp_data/dp_last SHALL hold stable while dp_valid && !dp_ready.
- dp_ready=1 continuously SHALL give one beat per cycle with no bubbles.
REQ-014 dp_last SHALL be 1 only on address DEPTH-1; on its acceptance, done pulses once and the FSM returns to IDLE.
REQ-015 Addresses SHALL not wrap: ld_ptr and dump pointer stop at DEPTH-1.

Reset
REQ-016 rst SHALL asynchronously force IDLE and zero all outputs, ld_ptr, dump pointer and quiet counter; RAM contents are not cleared.
REQ-017 rst mid-LOAD/RUN/DUMP SHALL abort at once; no write completes on the reset edge.

Configuration
REQ-018 Macro CONV_FRAME_MEM_FWD_EN:
- Defined: an engine write and a read to the same address in one cycle SHALL return the new result on read_data.
- Undefined: the same case SHALL return the old contents.

Structure
REQ-019 Package conv_frame_mem_pkg SHALL hold the state enum and DEPTH/AW/DW defaults.
REQ-020 Sub-module conv_frame_ram SHALL provide the single-clock RAM (1 write, 1 registered read, forwarding mux under the macro).

Verification
REQ-021 go, 2500 beats of ld_data=addr[7:0] -> ld_ready drops after beat 2499; start=1 next cycle.
REQ-022 In RUN, read_select=75 -> read_data=75 exactly one cycle later; read_select=3000 -> 0.
REQ-023 we=1, ws=10, result=0xA5 with read_select=10 same cycle -> read_data=0xA5 with macro, 0x0A without.
REQ-024 finish=1 with we pulses every 10 cycles -> stays RUN; we stops -> DUMP after 16 idle cycles.
REQ-025 DUMP with dp_ready toggling 1,0 -> 2500 beats in order, data stable on stalls, dp_last on beat 2499, single done pulse.
REQ-026 rst asserted mid-DUMP at beat 1200 -> outputs 0 and IDLE; next go reloads cleanly.
